// File: rtl/sram_mem_stage.sv
// Memory stage: 32-bit loads/stores to a 16-bit async SRAM as two half-word accesses.
// Latency: non-memory ops pass through in 0 cycles; memory ops take 2*WAIT_CYCLES+4 cycles, ready high only in the last.
// Backpressure: ready low freezes IF/ID/EXE, which hold every *_in signal stable until ready returns high.
module sram_mem_stage #(
    parameter int WORD_WIDTH      = 32,
    parameter int REG_FILE_DEPTH  = 4,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int WAIT_CYCLES     = 1,
    parameter int DATA_BASE       = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       MEM_R_EN_in,
    input  logic                       MEM_W_EN_in,
    input  logic                       WB_EN_in,
    input  logic [REG_FILE_DEPTH-1:0]  Dest_in,
    input  logic [WORD_WIDTH-1:0]      ALU_Res_in,
    input  logic [WORD_WIDTH-1:0]      Val_Rm_in,
    output logic                       WB_EN_out,
    output logic                       MEM_R_EN_out,
    output logic [REG_FILE_DEPTH-1:0]  Dest_out,
    output logic [WORD_WIDTH-1:0]      ALU_Res_out,
    output logic [WORD_WIDTH-1:0]      Mem_Data_out,
    output logic                       ready,
    output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
    output logic [SRAM_DATA_WIDTH-1:0] SRAM_DQ_out,
    output logic                       SRAM_DQ_oe,
    input  logic [SRAM_DATA_WIDTH-1:0] SRAM_DQ_in,
    output logic                       SRAM_WE_N
);

    localparam int SAW = SRAM_ADDR_WIDTH;
    localparam int SDW = SRAM_DATA_WIDTH;
    localparam logic [WORD_WIDTH-1:0] BASE_W    = WORD_WIDTH'(DATA_BASE);
    localparam logic [2:0]            WAIT_LAST = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          wait_q;
    logic [2:0]          wait_d;
    logic                wr_q;
    logic [SAW-1:0]      addr_q;
    logic [SDW-1:0]      dq_q;
    logic                oe_q;
    logic                we_n_q;
    logic [SDW-1:0]      lo_reg;
    logic [WORD_WIDTH-1:0] mem_data_q;

    logic                mem_req;
    logic                hold_done;
    logic                borrow;
    logic [SAW-2:0]      word_idx;
    logic [SAW-1:0]      addr_lo;
    logic [SAW-1:0]      addr_hi;

    logic                ld_lo;
    logic                ld_hi;
    logic                cap_lo;
    logic                cap_hi;
    logic                fin;

    // Pipeline control and result pass straight through to MEM/WB.
    assign WB_EN_out    = WB_EN_in;
    assign MEM_R_EN_out = MEM_R_EN_in;
    assign Dest_out     = Dest_in;
    assign ALU_Res_out  = ALU_Res_in;

    assign Mem_Data_out = mem_data_q;
    assign SRAM_ADDR    = addr_q;
    assign SRAM_DQ_out  = dq_q;
    assign SRAM_DQ_oe   = oe_q;
    assign SRAM_WE_N    = we_n_q;

    assign mem_req   = MEM_R_EN_in | MEM_W_EN_in;
    assign hold_done = (wait_q == WAIT_LAST);

    // Word index of (ALU_Res_in - DATA_BASE); the byte-offset bits only contribute a borrow.
    assign borrow   = (ALU_Res_in[1:0] < BASE_W[1:0]);
    assign word_idx = ALU_Res_in[SAW:2] - BASE_W[SAW:2] - {{(SAW-2){1'b0}}, borrow};
    assign addr_lo  = {word_idx, 1'b0};
    assign addr_hi  = {word_idx, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ready   = 1'b0;
        ld_lo   = 1'b0;
        ld_hi   = 1'b0;
        cap_lo  = 1'b0;
        cap_hi  = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready = ~mem_req;
                if (mem_req) begin
                    state_d = S_LO;
                    wait_d  = 3'd0;
                    ld_lo   = 1'b1;
                end
            end
            S_LO: begin
                if (hold_done) begin
                    state_d = S_HI;
                    wait_d  = 3'd0;
                    ld_hi   = 1'b1;
                    cap_lo  = ~wr_q;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_HI: begin
                if (hold_done) begin
                    state_d = S_DONE;
                    wait_d  = 3'd0;
                    cap_hi  = ~wr_q;
                    fin     = 1'b1;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pad-facing registers only move on state entry, so address and data are
    // stable for the whole time a half-word is being driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= 1'b0;
            addr_q     <= '0;
            dq_q       <= '0;
            oe_q       <= 1'b0;
            we_n_q     <= 1'b1;
            lo_reg     <= '0;
            mem_data_q <= '0;
        end else begin
            if (ld_lo) begin
                wr_q   <= MEM_W_EN_in;
                addr_q <= addr_lo;
                dq_q   <= Val_Rm_in[SDW-1:0];
                oe_q   <= MEM_W_EN_in;
                we_n_q <= ~MEM_W_EN_in;
            end
            if (ld_hi) begin
                addr_q <= addr_hi;
                dq_q   <= Val_Rm_in[2*SDW-1:SDW];
            end
            if (cap_lo) begin
                lo_reg <= SRAM_DQ_in;
            end
            // The high half is taken straight from the pad into the result word,
            // which then holds until the next load completes.
            if (cap_hi) begin
                mem_data_q <= {SRAM_DQ_in, lo_reg};
            end
            if (fin) begin
                oe_q   <= 1'b0;
                we_n_q <= 1'b1;
            end
        end
    end

endmodule
